// File: rtl/bcd_request_scheduler.sv
// rtl/bcd_request_scheduler.sv - round-robin arbiter driving a polled binary-to-BCD converter peripheral
module bcd_request_scheduler #(
  parameter logic [4:0] ADDR_DATA   = 5'h04,
  parameter logic [4:0] ADDR_INIT   = 5'h0C,
  parameter logic [4:0] ADDR_DONE   = 5'h10,
  parameter logic [4:0] ADDR_RESULT = 5'h14,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  output logic [1:0]  ack,
  output logic [31:0] result,
  output logic        error,
  output logic        busy,
  output logic        bus_chip_select,
  output logic [4:0]  bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [15:0] bus_data_out,
  input  logic [31:0] bus_data_in
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_INIT, POLL_RD, POLL_CHK, RD_RESULT, CAPTURE, ACK
  } state_t;

  state_t      state, state_next;
  logic [15:0] operand_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        grant_pick;
  logic [7:0]  poll_count_q;
  logic [31:0] result_q;
  logic        error_q;

  assign result = result_q;
  assign error  = error_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    ack             = 2'b00;
    busy            = (state != IDLE);
    bus_chip_select = 1'b0;
    bus_address     = 5'd0;
    bus_read        = 1'b0;
    bus_write       = 1'b0;
    bus_data_out    = 16'd0;
    // On a tie the requester that was not served last wins.
    if (req == 2'b11) grant_pick = ~last_grant_q;
    else              grant_pick = req[1];
    case (state)
      IDLE: begin
        if (|req) state_next = WR_DATA;
      end
      WR_DATA: begin
        bus_chip_select = 1'b1;
        bus_write       = 1'b1;
        bus_address     = ADDR_DATA;
        bus_data_out    = operand_q;
        state_next      = WR_INIT;
      end
      WR_INIT: begin
        bus_chip_select = 1'b1;
        bus_write       = 1'b1;
        bus_address     = ADDR_INIT;
        bus_data_out    = 16'h0001;
        state_next      = POLL_RD;
      end
      POLL_RD: begin
        bus_chip_select = 1'b1;
        bus_read        = 1'b1;
        bus_address     = ADDR_DONE;
        state_next      = POLL_CHK;
      end
      POLL_CHK: begin
        if (bus_data_in[0])              state_next = RD_RESULT;
        else if (poll_count_q < TIMEOUT) state_next = POLL_RD;
        else                             state_next = ACK;
      end
      RD_RESULT: begin
        bus_chip_select = 1'b1;
        bus_read        = 1'b1;
        bus_address     = ADDR_RESULT;
        state_next      = CAPTURE;
      end
      CAPTURE: state_next = ACK;
      ACK: begin
        ack        = grant_q ? 2'b10 : 2'b01;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      operand_q    <= 16'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      poll_count_q <= 8'd0;
      result_q     <= 32'd0;
      error_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_q   <= grant_pick;
            operand_q <= grant_pick ? req_data1 : req_data0;
          end
        end
        WR_INIT: poll_count_q <= 8'd0;
        POLL_CHK: begin
          if (!bus_data_in[0]) begin
            if (poll_count_q < TIMEOUT) poll_count_q <= poll_count_q + 8'd1;
            else                        error_q      <= 1'b1;
          end
        end
        CAPTURE: begin
          result_q <= bus_data_in;
          error_q  <= 1'b0;
        end
        ACK: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_request_scheduler.sv
// tb/tb_bcd_request_scheduler.sv - transaction-level model, converter responder and directed scenarios
module tb_bcd_request_scheduler;
  localparam logic [4:0] A_DATA = 5'h04, A_INIT = 5'h0C, A_DONE = 5'h10, A_RES = 5'h14;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] req_data0 = 16'd0, req_data1 = 16'd0;
  logic [1:0]  ack;
  logic [31:0] result;
  logic        error, busy, bus_chip_select, bus_read, bus_write;
  logic [4:0]  bus_address;
  logic [15:0] bus_data_out;
  logic [31:0] bus_data_in = 32'd0;

  bcd_request_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .req_data0(req_data0), .req_data1(req_data1),
    .ack(ack), .result(result), .error(error), .busy(busy),
    .bus_chip_select(bus_chip_select), .bus_address(bus_address), .bus_read(bus_read),
    .bus_write(bus_write), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct { int who; logic [15:0] operand; int dafter; int req_cyc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_result = 32'd0;
  int          model_last = 1;
  int          done_after = 0;

  logic [15:0] conv_operand = 16'd0, init_val = 16'd0;
  int          start_cyc = 0, done_reads = 0, result_reads = 0;
  logic [1:0]  prev_ack = 2'b00;
  int          acks_seen = 0;
  logic [1:0]  ack_log[$];
  logic [31:0] last_ack_result = 32'd0;
  logic        last_ack_error = 1'b0;
  int          last_done_reads = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = 32'd0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Bus protocol, transaction scoreboard and converter peripheral, all on the falling edge.
  always @(negedge clock) begin : monitor
    exp_t e;
    logic timed_out;
    checks++;
    if ((bus_read && bus_write) || ((bus_read || bus_write) && !bus_chip_select) ||
        (bus_chip_select && !(bus_read || bus_write)) || (bus_chip_select && !busy) ||
        (bus_write && bus_address != A_DATA && bus_address != A_INIT) ||
        (bus_read && bus_address != A_DONE && bus_address != A_RES) ||
        (ack == 2'b11) || (ack != 2'b00 && prev_ack != 2'b00) || (ack != 2'b00 && !busy)) begin
      errors++;
      $display("FAIL protocol cyc=%0d cs=%b rd=%b wr=%b addr=%0h ack=%b prev_ack=%b busy=%b",
               cyc, bus_chip_select, bus_read, bus_write, bus_address, ack, prev_ack, busy);
    end
    prev_ack = ack;
    if (ack != 2'b00) begin
      acks_seen++;
      ack_log.push_back(ack);
      last_ack_result = result;
      last_ack_error  = error;
      last_done_reads = done_reads;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        timed_out = (e.dafter > 255);
        if (!timed_out) model_result = to_bcd(int'(e.operand));
        chk("ack_who", 32'(ack), 32'(1 << e.who));
        chk("result", result, model_result);
        chk("error", 32'(error), 32'(timed_out));
        chk("operand_written", 32'(conv_operand), 32'(e.operand));
        chk("init_write", 32'(init_val), 32'd1);
        chk("done_reads", 32'(done_reads), timed_out ? 32'd256 : 32'(e.dafter + 1));
        chk("result_reads", 32'(result_reads), timed_out ? 32'd0 : 32'd1);
        chk("latency", 32'(cyc - start_cyc), timed_out ? 32'd514 : 32'(6 + 2 * e.dafter));
        if (e.req_cyc >= 0) chk("req_to_ack", 32'(cyc - e.req_cyc), 32'd7);
      end
    end
    if (bus_chip_select && bus_write) begin
      if (bus_address == A_DATA) begin
        conv_operand = bus_data_out;
        start_cyc    = cyc;
        done_reads   = 0;
        result_reads = 0;
        init_val     = 16'd0;
      end else begin
        init_val = bus_data_out;
      end
    end
    if (bus_chip_select && bus_read) begin
      if (bus_address == A_DONE) begin
        done_reads++;
        bus_data_in = {31'd0, done_reads > done_after};
      end else begin
        result_reads++;
        bus_data_in = to_bcd(int'(conv_operand));
      end
    end
  end

  task automatic push(input int who, input logic [15:0] op, input int rc);
    exp_t e;
    e.who = who; e.operand = op; e.dafter = done_after; e.req_cyc = rc;
    exp_q.push_back(e);
    model_last = who;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("wait_budget", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    req = 2'b00;
    repeat (2) @(negedge clock);
  endtask

  // Predict grant order by round-robin, then hold each req until its quota of acks is seen.
  task automatic serve(input int r0, input int r1, input bit scramble, input bit lit);
    int left0 = r0, left1 = r1, n = 0, pick, rc;
    logic [15:0] d0 = req_data0, d1 = req_data1;
    rc = lit ? cyc : -1;
    while (left0 + left1 > 0) begin
      if (left0 > 0 && left1 > 0) pick = (model_last == 1) ? 0 : 1;
      else                        pick = (left0 > 0) ? 0 : 1;
      push(pick, (pick == 1) ? d1 : d0, rc);
      rc = -1;
      if (pick == 1) left1--; else left0--;
    end
    left0 = r0; left1 = r1;
    req = {left1 > 0, left0 > 0};
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
      if (ack != 2'b00) begin
        req_data0 = d0; req_data1 = d1;
        if (ack[0]) begin left0--; if (left0 <= 0) req[0] = 1'b0; end
        if (ack[1]) begin left1--; if (left1 <= 0) req[1] = 1'b0; end
      end else if (scramble && busy) begin
        req_data0 = 16'($urandom); req_data1 = 16'($urandom);
      end
    end
    req_data0 = d0; req_data1 = d1;
    wait_done(10);
  endtask

  initial begin
    int n, saved;
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_strobes", {29'd0, bus_chip_select, bus_read, bus_write}, 32'd0);
    chk("rst_addr", 32'(bus_address), 32'd0);
    chk("rst_dout", 32'(bus_data_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    done_after = 3; req_data0 = 16'hCAFE;
    serve(1, 0, 0, 0);
    chk("cafe_result", last_ack_result, 32'h00051966);
    chk("cafe_done_reads", 32'(last_done_reads), 32'd4);
    chk("cafe_error", 32'(last_ack_error), 32'd0);

    done_after = 0; req_data1 = 16'd9999; ack_log.delete();
    serve(0, 1, 0, 1);
    chk("min_lat_ack", 32'(ack_log[0]), 32'h2);
    chk("min_lat_result", last_ack_result, 32'h00009999);

    done_after = 1; req_data1 = 16'h0042;
    push(1, 16'h0042, -1);
    req = 2'b10;
    repeat (3) @(negedge clock);
    req = 2'b00; req_data1 = 16'hFFFF;
    wait_done(100);

    done_after = 1000; req_data0 = 16'h1234;
    serve(1, 0, 0, 0);
    chk("to_error", 32'(last_ack_error), 32'd1);
    chk("to_done_reads", 32'(last_done_reads), 32'd256);
    chk("to_result_kept", last_ack_result, 32'h00000066);

    done_after = 2; req_data0 = 16'd1; req_data1 = 16'd65535;
    serve(2, 2, 1, 0);

    done_after = 50; req_data0 = 16'h0777; req = 2'b01; n = 0;
    while (!(bus_read && bus_address == A_DONE) && n < 20) begin @(negedge clock); n++; end
    chk("reached_poll", 32'(bus_read && bus_address == A_DONE), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; req = 2'b00; model_result = 32'd0; model_last = 1;
    chk("mid_rst_strobes", {29'd0, bus_chip_select, bus_read, bus_write}, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    saved = acks_seen;
    repeat (10) @(negedge clock);
    chk("mid_rst_no_ack", 32'(acks_seen), 32'(saved));

    done_after = 0; req_data0 = 16'd12; req_data1 = 16'd34; ack_log.delete();
    serve(1, 1, 0, 0);
    chk("tie_first", 32'(ack_log[0]), 32'h1);
    chk("tie_second", 32'(ack_log[1]), 32'h2);

    done_after = 1; req_data0 = 16'd500; saved = acks_seen;
    serve(2, 0, 0, 0);
    chk("held_req_acks", 32'(acks_seen - saved), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
